// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: operation codes,
// FSM state encoding, and small operand helpers.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  localparam logic [5:0] OP_MULT  = 6'b001011;
  localparam logic [5:0] OP_MULTU = 6'b011000;
  localparam logic [5:0] OP_DIV   = 6'b001100;
  localparam logic [5:0] OP_MADD  = 6'b011001;
  localparam logic [5:0] OP_MSUB  = 6'b011010;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MTLO  = 6'b010010;
  localparam logic [5:0] OP_MFHI  = 6'b001111;
  localparam logic [5:0] OP_MFLO  = 6'b010000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    K_MULT,
    K_MULTU,
    K_MADD,
    K_MSUB,
    K_DIV
  } kind_t;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_t;

  // Any opcode that reads or writes HI/LO; these are the ones that must stall.
  function automatic logic is_hilo_op(input logic [5:0] op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_MADD, OP_MSUB,
      OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v,
                                              input logic            is_signed);
    return (is_signed && v[XLEN-1]) ? -v : v;
  endfunction

  function automatic kind_t mul_kind(input logic [5:0] op);
    case (op)
      OP_MULTU: return K_MULTU;
      OP_MADD:  return K_MADD;
      OP_MSUB:  return K_MSUB;
      default:  return K_MULT;
    endcase
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// EX-stage request / HI-LO result bundle between the pipeline and the
// multiply/divide sequencer.
interface hilo_muldiv_ctrl_if;
  import muldiv_pkg::*;

  logic            Start;
  logic [5:0]      ALUOp;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            Stall;
  logic            Busy;
  logic            Done;
  logic [XLEN-1:0] HI;
  logic [XLEN-1:0] LO;

  modport master (
    output Start, ALUOp, A, B,
    input  Stall, Busy, Done, HI, LO
  );

  modport slave (
    input  Start, ALUOp, A, B,
    output Stall, Busy, Done, HI, LO
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on a 2*XLEN-bit
// accumulator; purely combinational.
module muldiv_step
  import muldiv_pkg::*;
(
  input  step_mode_t         mode,
  input  logic [2*XLEN-1:0]  acc,
  input  logic [XLEN-1:0]    operand,
  output logic [2*XLEN-1:0]  acc_next,
  output logic               q_bit
);

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rem_shift;
  logic [XLEN-1:0] rem_diff;
  logic            rem_ge;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    acc_next = '0;
    q_bit    = 1'b0;

    // Multiply: upper half accumulates the multiplicand, lower half holds the
    // remaining multiplier bits; the whole pair shifts right with the carry.
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);

    // Divide: {remainder, dividend} shifts left by one, then a trial subtract.
    rem_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    rem_ge    = (rem_shift >= {1'b0, operand});
    rem_diff  = rem_shift[XLEN-1:0] - operand;

    if (mode == STEP_MUL) begin
      acc_next = {mul_sum, acc[XLEN-1:1]};
    end else begin
      q_bit = rem_ge;
      // Quotient slot is left clear; the parent merges q_bit into bit 0.
      acc_next = {(rem_ge ? rem_diff : rem_shift[XLEN-1:0]), acc[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner for the MIPS pipeline: sequences 32-step multiply/divide,
// applies sign fix-up and accumulate, and stalls HI/LO-class ops while busy.
module hilo_muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  hilo_muldiv_ctrl_if.slave bus
);

  state_t            state_q, state_d;
  kind_t             kind_q, kind_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              neg_lo_q, neg_lo_d;
  logic              neg_hi_q, neg_hi_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              done_q, done_d;

  step_mode_t        step_mode;
  logic [2*XLEN-1:0] step_acc;
  logic              step_q_bit;
  logic              mul_signed;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  assign step_mode  = (state_q == ST_DIV) ? STEP_DIV : STEP_MUL;
  assign mul_signed = (bus.ALUOp != OP_MULTU);

  muldiv_step u_step (
    .mode     (step_mode),
    .acc      (acc_q),
    .operand  (opnd_q),
    .acc_next (step_acc),
    .q_bit    (step_q_bit)
  );

  // Sign fix-up: product as one 64-bit value, quotient/remainder separately.
  assign prod_fix = neg_lo_q ? -acc_q : acc_q;
  assign quo_fix  = neg_lo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = neg_hi_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          case (bus.ALUOp)
            OP_MTHI: hi_d = bus.A;
            OP_MTLO: lo_d = bus.A;
            OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
              acc_d    = {{XLEN{1'b0}}, abs_val(bus.A, mul_signed)};
              opnd_d   = abs_val(bus.B, mul_signed);
              neg_lo_d = mul_signed & (bus.A[XLEN-1] ^ bus.B[XLEN-1]);
              neg_hi_d = 1'b0;
              kind_d   = mul_kind(bus.ALUOp);
              cnt_d    = '0;
              state_d  = ST_MUL;
            end
            OP_DIV: begin
              kind_d = K_DIV;
              cnt_d  = '0;
              if (bus.B == '0) begin
                // Divide-by-zero result is staged as-is and written by FIX.
                acc_d    = {bus.A, {XLEN{1'b1}}};
                neg_lo_d = 1'b0;
                neg_hi_d = 1'b0;
                state_d  = ST_FIX;
              end else begin
                acc_d    = {{XLEN{1'b0}}, abs_val(bus.A, 1'b1)};
                opnd_d   = abs_val(bus.B, 1'b1);
                neg_lo_d = bus.A[XLEN-1] ^ bus.B[XLEN-1];
                neg_hi_d = bus.A[XLEN-1];
                state_d  = ST_DIV;
              end
            end
            default: ;
          endcase
        end
      end

      ST_MUL, ST_DIV: begin
        acc_d = (state_q == ST_DIV)
              ? (step_acc | {{(2*XLEN-1){1'b0}}, step_q_bit})
              : step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN - 1)) state_d = ST_FIX;
      end

      ST_FIX: begin
        case (kind_q)
          K_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_fix;
          K_MSUB:  {hi_d, lo_d} = {hi_q, lo_q} - prod_fix;
          K_DIV: begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
          default: {hi_d, lo_d} = prod_fix;
        endcase
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (Rst) begin
      state_q  <= ST_IDLE;
      kind_q   <= K_MULT;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.Busy  = (state_q != ST_IDLE);
  assign bus.Stall = bus.Busy & bus.Start & is_hilo_op(bus.ALUOp);
  assign bus.Done  = done_q;
  assign bus.HI    = hi_q;
  assign bus.LO    = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed vectors plus randomized
// operations checked against a plain-arithmetic HI/LO model.
module tb_hilo_muldiv_ctrl;

  localparam logic [5:0] C_MULT  = 6'b001011;
  localparam logic [5:0] C_MULTU = 6'b011000;
  localparam logic [5:0] C_DIV   = 6'b001100;
  localparam logic [5:0] C_MADD  = 6'b011001;
  localparam logic [5:0] C_MSUB  = 6'b011010;
  localparam logic [5:0] C_MTHI  = 6'b010001;
  localparam logic [5:0] C_MTLO  = 6'b010010;
  localparam logic [5:0] C_MFHI  = 6'b001111;
  localparam logic [5:0] C_MFLO  = 6'b010000;
  localparam logic [5:0] C_ADD   = 6'b100000;

  logic Clk = 1'b0;
  logic Rst;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] m_hi, m_lo;

  hilo_muldiv_ctrl_if bus();

  hilo_muldiv_ctrl dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Reference model: HI/LO effect of one operation, in plain 64-bit arithmetic.
  function automatic void model_apply(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] hl;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hl = {m_hi, m_lo};
    case (op)
      C_MULT:  hl = 64'(sa * sb);
      C_MULTU: hl = {32'b0, a} * {32'b0, b};
      C_MADD:  hl = hl + 64'(sa * sb);
      C_MSUB:  hl = hl - 64'(sa * sb);
      C_DIV: begin
        if (b == 32'b0) hl = {a, 32'hFFFF_FFFF};
        else begin
          q  = sa / sb;
          r  = sa % sb;
          hl = {r[31:0], q[31:0]};
        end
      end
      C_MTHI:  hl[63:32] = a;
      C_MTLO:  hl[31:0]  = a;
      default: ;
    endcase
    {m_hi, m_lo} = hl;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issues one arithmetic op and follows it to its Done cycle.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit lead_wait, input bit tail_check, input string tag);
    int n;
    int exp_busy;
    bit stable;
    exp_busy = (op == C_DIV && b == 32'b0) ? 1 : 33;
    if (lead_wait) @(negedge Clk);
    bus.Start = 1'b1; bus.ALUOp = op; bus.A = a; bus.B = b;
    #1;
    checks++;
    if (bus.Stall !== 1'b0) begin
      errors++; $display("FAIL %s issue_stall: got %b expected 0", tag, bus.Stall);
    end
    @(negedge Clk);
    bus.Start = 1'b0; bus.ALUOp = C_ADD; bus.A = $urandom; bus.B = $urandom;
    n = 0; stable = 1'b1;
    while (bus.Busy === 1'b1 && n < 100) begin
      n++;
      if (bus.HI !== m_hi || bus.LO !== m_lo) stable = 1'b0;
      @(negedge Clk);
    end
    model_apply(op, a, b);
    checks++;
    if (n != exp_busy) begin
      errors++; $display("FAIL %s busy_cycles: got %0d expected %0d", tag, n, exp_busy);
    end
    checks++;
    if (!stable) begin
      errors++; $display("FAIL %s hilo_stable_while_busy: got changed expected held", tag);
    end
    checks++;
    if (bus.Done !== 1'b1) begin
      errors++; $display("FAIL %s done_pulse: got %b expected 1", tag, bus.Done);
    end
    checks++;
    if (bus.HI !== m_hi || bus.LO !== m_lo) begin
      errors++; $display("FAIL %s result: got HI=%h LO=%h expected HI=%h LO=%h", tag, bus.HI, bus.LO, m_hi, m_lo);
    end
    if (tail_check) begin
      @(negedge Clk);
      checks++;
      if (bus.Done !== 1'b0) begin
        errors++; $display("FAIL %s done_width: got %b expected 0", tag, bus.Done);
      end
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    bus.Start = 1'b1; bus.ALUOp = C_MTHI; bus.A = 32'hFFFF_FFFF; bus.B = 32'h0;
    repeat (3) @(negedge Clk);
    m_hi = '0; m_lo = '0;
    checks++;
    if (bus.HI !== 32'h0 || bus.LO !== 32'h0) begin
      errors++; $display("FAIL reset_hilo: got HI=%h LO=%h expected 0", bus.HI, bus.LO);
    end
    checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Stall !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got busy=%b done=%b stall=%b expected 0", bus.Busy, bus.Done, bus.Stall);
    end
    bus.Start = 1'b0;
    Rst = 1'b0;
  endtask

  task automatic test_spec_vectors();
    run_op(C_MULT, 32'hFFFF_FFFD, 32'h5, 1, 1, "mult_neg");
    checks++;
    if ({bus.HI, bus.LO} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      errors++; $display("FAIL mult_neg_const: got %h_%h expected FFFFFFFF_FFFFFFF1", bus.HI, bus.LO);
    end
    run_op(C_MULTU, 32'hFFFF_FFFF, 32'h2, 1, 1, "multu");
    checks++;
    if ({bus.HI, bus.LO} !== 64'h0000_0001_FFFF_FFFE) begin
      errors++; $display("FAIL multu_const: got %h_%h expected 00000001_FFFFFFFE", bus.HI, bus.LO);
    end
    run_op(C_MADD, 32'h1, 32'h1, 1, 1, "madd");
    checks++;
    if ({bus.HI, bus.LO} !== 64'h0000_0001_FFFF_FFFF) begin
      errors++; $display("FAIL madd_const: got %h_%h expected 00000001_FFFFFFFF", bus.HI, bus.LO);
    end
    run_op(C_DIV, 32'hFFFF_FFF9, 32'h2, 1, 1, "div_neg");
    checks++;
    if (bus.HI !== 32'hFFFF_FFFF || bus.LO !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL div_neg_const: got HI=%h LO=%h expected HI=FFFFFFFF LO=FFFFFFFD", bus.HI, bus.LO);
    end
    run_op(C_DIV, 32'h7, 32'h0, 1, 1, "div_zero");
    checks++;
    if (bus.HI !== 32'h7 || bus.LO !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div_zero_const: got HI=%h LO=%h expected HI=00000007 LO=FFFFFFFF", bus.HI, bus.LO);
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] v;
    @(negedge Clk);
    bus.Start = 1'b1; bus.ALUOp = C_MTHI; bus.A = 32'h1234_5678;
    #1;
    checks++;
    if (bus.Stall !== 1'b0) begin
      errors++; $display("FAIL mthi_stall: got %b expected 0", bus.Stall);
    end
    model_apply(C_MTHI, 32'h1234_5678, 32'h0);
    @(negedge Clk);
    bus.ALUOp = C_MFLO; bus.A = $urandom;
    #1;
    checks++;
    if (bus.HI !== 32'h1234_5678 || bus.LO !== m_lo) begin
      errors++; $display("FAIL mthi_write: got HI=%h LO=%h expected HI=12345678 LO=%h", bus.HI, bus.LO, m_lo);
    end
    checks++;
    if (bus.Stall !== 1'b0 || bus.Busy !== 1'b0) begin
      errors++; $display("FAIL mflo_idle: got stall=%b busy=%b expected 0", bus.Stall, bus.Busy);
    end
    @(negedge Clk);
    checks++;
    if (bus.LO !== m_lo || bus.Done !== 1'b0) begin
      errors++; $display("FAIL mflo_noop: got LO=%h done=%b expected LO=%h done=0", bus.LO, bus.Done, m_lo);
    end
    v = $urandom;
    bus.ALUOp = C_MTLO; bus.A = v;
    model_apply(C_MTLO, v, 32'h0);
    @(negedge Clk);
    bus.Start = 1'b0;
    checks++;
    if (bus.LO !== v || bus.HI !== 32'h1234_5678 || bus.Done !== 1'b0) begin
      errors++; $display("FAIL mtlo_write: got HI=%h LO=%h done=%b expected HI=12345678 LO=%h done=0", bus.HI, bus.LO, bus.Done, v);
    end
  endtask

  task automatic test_stall();
    logic [31:0] a, b;
    bit exp_stall;
    a = $urandom; b = $urandom;
    @(negedge Clk);
    bus.Start = 1'b1; bus.ALUOp = C_MULT; bus.A = a; bus.B = b;
    @(negedge Clk);
    for (int k = 1; k <= 40; k++) begin
      bus.ALUOp = (k >= 5 && k <= 8) ? C_ADD : C_MFHI;
      bus.A = $urandom;
      #1;
      exp_stall = (k <= 33) && !(k >= 5 && k <= 8);
      checks++;
      if (bus.Stall !== exp_stall) begin
        errors++; $display("FAIL stall_cycle%0d: got %b expected %b", k, bus.Stall, exp_stall);
      end
      if (k == 34) begin
        model_apply(C_MULT, a, b);
        checks++;
        if (bus.Done !== 1'b1 || bus.HI !== m_hi || bus.LO !== m_lo) begin
          errors++; $display("FAIL stall_done: got done=%b HI=%h LO=%h expected done=1 HI=%h LO=%h", bus.Done, bus.HI, bus.LO, m_hi, m_lo);
        end
      end
      @(negedge Clk);
    end
    bus.Start = 1'b0;
  endtask

  task automatic test_random();
    logic [5:0] ops [5];
    logic [5:0] op;
    ops[0] = C_MULT; ops[1] = C_MULTU; ops[2] = C_MADD; ops[3] = C_MSUB; ops[4] = C_DIV;
    for (int i = 0; i < 30; i++) begin
      op = ops[$urandom_range(0, 4)];
      run_op(op, pick_operand(), pick_operand(), 1, 1, "random");
    end
  endtask

  task automatic test_back_to_back();
    run_op(C_MULT,  $urandom, $urandom, 1, 0, "b2b_first");
    run_op(C_DIV,   $urandom, $urandom | 32'h1, 0, 0, "b2b_second");
    run_op(C_MSUB,  $urandom, $urandom, 0, 0, "b2b_third");
    run_op(C_DIV,   $urandom, 32'h0, 0, 1, "b2b_divzero");
  endtask

  task automatic test_reset_abort();
    bit saw_done;
    @(negedge Clk);
    bus.Start = 1'b1; bus.ALUOp = C_DIV; bus.A = $urandom; bus.B = $urandom | 32'h1;
    @(negedge Clk);
    bus.Start = 1'b0; bus.ALUOp = C_ADD;
    repeat (9) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    m_hi = '0; m_lo = '0;
    checks++;
    if (bus.HI !== 32'h0 || bus.LO !== 32'h0 || bus.Busy !== 1'b0) begin
      errors++; $display("FAIL abort_state: got HI=%h LO=%h busy=%b expected 0 0 0", bus.HI, bus.LO, bus.Busy);
    end
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.Done !== 1'b0) saw_done = 1'b1;
      @(negedge Clk);
    end
    checks++;
    if (saw_done) begin
      errors++; $display("FAIL abort_done: got pulse expected none");
    end
    run_op(C_MULT, $urandom, $urandom, 1, 1, "after_abort");
  endtask

  initial begin
    bus.Start = 1'b0; bus.ALUOp = 6'b0; bus.A = '0; bus.B = '0;
    m_hi = '0; m_lo = '0;
    test_reset();
    test_spec_vectors();
    test_mthi_mtlo();
    test_stall();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
